// File: rtl/phoneme_queue_pkg.sv
// phoneme_queue_pkg: shared states, register map and status layout for the phoneme queue
package phoneme_queue_pkg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} state_t;
  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL = 3'd2;
  localparam int ST_FULL = 8;
  localparam int ST_EMPTY = 9;
  localparam int ST_PLAYING = 10;
  localparam int ST_OVF = 11;
  localparam int ST_TMO = 12;
  localparam int DEFAULT_DEPTH = 16;
endpackage

// File: rtl/phoneme_fifo.sv
// phoneme_fifo: synchronous byte FIFO with push, pop, flush and occupancy count
module phoneme_fifo
  import phoneme_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  assign do_pop = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  always_comb begin
    wr_d = flush ? '0 : wr_q + {{(AW-1){1'b0}}, do_push};
    rd_d = flush ? '0 : rd_q + {{(AW-1){1'b0}}, do_pop};
    cnt_d = flush ? '0 : cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/phoneme_queue_controller.sv
// phoneme_queue_controller: 68000-bus phoneme FIFO feeding a speech engine through a start/busy handshake
module phoneme_queue_controller
  import phoneme_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Reset_H,
  input  logic        VoiceSelect_H,
  input  logic        AS_L,
  input  logic        UDS_L,
  input  logic        LDS_L,
  input  logic        RW,
  input  logic [2:0]  Address,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        VoiceDtack_L,
  output logic [7:0]  phoneme_sel,
  output logic        start_phoneme_output,
  input  logic        phoneme_speech_busy,
  output logic        Voice_IRQ_L
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  state_t state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0] sel_q, sel_d;
  logic done_q, done_d, dtack_q, dtack_d, irq_en_q, irq_en_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic access, wr_acc, push, pop, ctrl_wr, flush, clr, tmo_set, rd_en;
  logic full, empty;
  logic [7:0] fifo_dout;
  logic [AW:0] count;
  logic [15:0] status, rdata;
  logic unused_hi;
  assign unused_hi = ^DataIn[15:8];
  phoneme_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(Clk),
    .rst(Reset_H),
    .push(push),
    .pop(pop),
    .flush(flush),
    .din(DataIn[7:0]),
    .dout(fifo_dout),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_comb begin
    access = VoiceSelect_H && !AS_L && (!UDS_L || !LDS_L) && !done_q;
    wr_acc = access && !RW;
    push = wr_acc && Address == REG_DATA;
    ctrl_wr = wr_acc && Address == REG_CTRL;
    flush = ctrl_wr && DataIn[0];
    clr = ctrl_wr && DataIn[1];
    done_d = AS_L ? 1'b0 : (access || done_q);
    dtack_d = access ? 1'b0 : AS_L ? 1'b1 : dtack_q;
    irq_en_d = ctrl_wr ? DataIn[2] : irq_en_q;
    state_d = state_q;
    sel_d = sel_q;
    tcnt_d = tcnt_q;
    pop = 1'b0;
    tmo_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !flush) begin
          pop = 1'b1;
          sel_d = fifo_dout;
          state_d = S_START;
        end
      end
      S_START: begin
        tcnt_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (phoneme_speech_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (tcnt_d == TW'(BUSY_TIMEOUT)) begin
            tmo_set = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: state_d = phoneme_speech_busy ? S_WAIT_DONE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ovf_d = (ovf_q && !clr) || (push && full && !pop);
    tmo_d = (tmo_q && !clr) || tmo_set;
  end
  always_comb begin
    status = '0;
    status[6:0] = 7'(count);
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_PLAYING] = state_q != S_IDLE;
    status[ST_OVF] = ovf_q;
    status[ST_TMO] = tmo_q;
    rdata = Address == REG_STATUS ? status : Address == REG_CTRL ? {13'b0, irq_en_q, 2'b00} : 16'h0000;
    rd_en = VoiceSelect_H && !AS_L && RW && (!UDS_L || !LDS_L);
  end
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      state_q <= S_IDLE;
      tcnt_q <= '0;
      sel_q <= 8'h00;
      done_q <= 1'b0;
      dtack_q <= 1'b1;
      irq_en_q <= 1'b0;
      ovf_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q <= tcnt_d;
      sel_q <= sel_d;
      done_q <= done_d;
      dtack_q <= dtack_d;
      irq_en_q <= irq_en_d;
      ovf_q <= ovf_d;
      tmo_q <= tmo_d;
    end
  end
  assign DataOut = rd_en ? rdata : 'z;
  assign VoiceDtack_L = dtack_q;
  assign phoneme_sel = sel_q;
  assign start_phoneme_output = state_q == S_START;
  assign Voice_IRQ_L = !(irq_en_q && empty && state_q == S_IDLE);
endmodule

// File: tb/tb_phoneme_queue_controller.sv
// tb_phoneme_queue_controller: directed bus/playback scenarios with hand-computed expectations
`define CHECK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin failures++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end

module tb_phoneme_queue_controller;
  logic Clk = 1'b0;
  logic Reset_H, VoiceSelect_H, AS_L, UDS_L, LDS_L, RW, busy;
  logic [2:0] Address;
  logic [15:0] DataIn;
  wire [15:0] DataOut;
  wire VoiceDtack_L, start_phoneme_output, Voice_IRQ_L;
  wire [7:0] phoneme_sel;
  int checks = 0, failures = 0;
  int cyc = 0, starts = 0, last_start_cyc = 0, pulse_err = 0, space_err = 0;
  int t0, t_fall;
  logic [7:0] last_sel = 8'h00;
  logic prev_start = 1'b0;
  logic [15:0] d;
  phoneme_queue_controller dut (
    .Clk(Clk),
    .Reset_H(Reset_H),
    .VoiceSelect_H(VoiceSelect_H),
    .AS_L(AS_L),
    .UDS_L(UDS_L),
    .LDS_L(LDS_L),
    .RW(RW),
    .Address(Address),
    .DataIn(DataIn),
    .DataOut(DataOut),
    .VoiceDtack_L(VoiceDtack_L),
    .phoneme_sel(phoneme_sel),
    .start_phoneme_output(start_phoneme_output),
    .phoneme_speech_busy(busy),
    .Voice_IRQ_L(Voice_IRQ_L)
  );
  always #10 Clk = ~Clk;
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    prev_start <= start_phoneme_output;
    if (start_phoneme_output) begin
      starts <= starts + 1;
      last_sel <= phoneme_sel;
      last_start_cyc <= cyc;
      if (prev_start) pulse_err <= pulse_err + 1;
      if (starts > 0 && cyc - last_start_cyc < 4) space_err <= space_err + 1;
    end
  end
  task automatic bus_cycle(input logic rw, input logic [2:0] a, input logic [15:0] wd, output logic [15:0] rd);
    logic ok;
    @(negedge Clk);
    VoiceSelect_H = 1'b1;
    RW = rw;
    Address = a;
    DataIn = wd;
    UDS_L = 1'b0;
    LDS_L = 1'b0;
    AS_L = 1'b0;
    ok = 1'b0;
    rd = 16'h0000;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge Clk);
      if (!VoiceDtack_L) begin
        ok = 1'b1;
        rd = DataOut;
      end
    end
    `CHECK("dtack_assert", ok, 1'b1)
    AS_L = 1'b1;
    @(negedge Clk);
    `CHECK("dtack_release", VoiceDtack_L, 1'b1)
    VoiceSelect_H = 1'b0;
    UDS_L = 1'b1;
    LDS_L = 1'b1;
    RW = 1'b1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] wd);
    logic [15:0] dummy;
    bus_cycle(1'b0, a, wd, dummy);
  endtask
  task automatic wait_starts(input int n, input int limit);
    for (int i = 0; i < limit && starts < n; i++) @(negedge Clk);
    `CHECK("start_count", starts, n)
  endtask
  initial begin
    Reset_H = 1'b1;
    VoiceSelect_H = 1'b0;
    AS_L = 1'b1;
    UDS_L = 1'b1;
    LDS_L = 1'b1;
    RW = 1'b1;
    Address = 3'd0;
    DataIn = 16'h0000;
    busy = 1'b0;
    repeat (3) @(negedge Clk);
    `CHECK("rst_dtack", VoiceDtack_L, 1'b1)
    `CHECK("rst_irq", Voice_IRQ_L, 1'b1)
    `CHECK("rst_start", start_phoneme_output, 1'b0)
    `CHECK("rst_sel", phoneme_sel, 8'h00)
    Reset_H = 1'b0;
    bus_cycle(1'b1, 3'd1, 16'h0, d);
    `CHECK("rst_status", d, 16'h0200)
    bus_cycle(1'b1, 3'd2, 16'h0, d);
    `CHECK("rst_ctrl", d, 16'h0000)
    wr(3'd5, 16'hFFFF);
    bus_cycle(1'b1, 3'd5, 16'h0, d);
    `CHECK("unused_read", d, 16'h0000)
    bus_cycle(1'b1, 3'd1, 16'h0, d);
    `CHECK("unused_write_ignored", d, 16'h0200)
    wr(3'd0, 16'h0015);
    wait_starts(1, 10);
    `CHECK("first_sel", last_sel, 8'h15)
    busy = 1'b1;
    bus_cycle(1'b1, 3'd1, 16'h0, d);
    `CHECK("status_playing", d, 16'h0600)
    busy = 1'b0;
    repeat (2) @(negedge Clk);
    bus_cycle(1'b1, 3'd1, 16'h0, d);
    `CHECK("status_idle", d, 16'h0200)
    busy = 1'b1;
    for (int i = 0; i < 17; i++) wr(3'd0, 16'h0020 + 16'(i));
    `CHECK("fill_starts", starts, 2)
    `CHECK("fill_sel", last_sel, 8'h20)
    bus_cycle(1'b1, 3'd1, 16'h0, d);
    `CHECK("status_full", d, 16'h0510)
    wr(3'd0, 16'h0031);
    bus_cycle(1'b1, 3'd1, 16'h0, d);
    `CHECK("status_ovf", d, 16'h0D10)
    wr(3'd2, 16'h0003);
    bus_cycle(1'b1, 3'd1, 16'h0, d);
    `CHECK("status_flushed", d, 16'h0600)
    busy = 1'b0;
    repeat (5) @(negedge Clk);
    `CHECK("flush_no_start", starts, 2)
    bus_cycle(1'b1, 3'd1, 16'h0, d);
    `CHECK("status_after_flush", d, 16'h0200)
    wr(3'd0, 16'h0001);
    wr(3'd0, 16'h0002);
    wait_starts(3, 20);
    `CHECK("hs_sel1", last_sel, 8'h01)
    repeat (3) @(negedge Clk);
    busy = 1'b1;
    repeat (20) @(negedge Clk);
    `CHECK("hs_hold", starts, 3)
    busy = 1'b0;
    t_fall = cyc;
    wait_starts(4, 20);
    `CHECK("hs_sel2", last_sel, 8'h02)
    `CHECK("hs_after_fall", last_start_cyc, t_fall + 2)
    busy = 1'b1;
    repeat (3) @(negedge Clk);
    busy = 1'b0;
    repeat (3) @(negedge Clk);
    bus_cycle(1'b1, 3'd1, 16'h0, d);
    `CHECK("hs_idle", d, 16'h0200)
    wr(3'd0, 16'h000A);
    wr(3'd0, 16'h000B);
    wait_starts(5, 20);
    `CHECK("tmo_sel1", last_sel, 8'h0A)
    t0 = last_start_cyc;
    wait_starts(6, 400);
    `CHECK("tmo_sel2", last_sel, 8'h0B)
    `CHECK("tmo_gap", last_start_cyc - t0, 257)
    busy = 1'b1;
    bus_cycle(1'b1, 3'd1, 16'h0, d);
    `CHECK("status_tmo", d, 16'h1600)
    wr(3'd2, 16'h0002);
    bus_cycle(1'b1, 3'd1, 16'h0, d);
    `CHECK("tmo_cleared", d, 16'h0600)
    busy = 1'b0;
    repeat (3) @(negedge Clk);
    wr(3'd2, 16'h0004);
    @(negedge Clk);
    `CHECK("irq_idle_empty", Voice_IRQ_L, 1'b0)
    bus_cycle(1'b1, 3'd2, 16'h0, d);
    `CHECK("ctrl_read", d, 16'h0004)
    busy = 1'b1;
    wr(3'd0, 16'h0041);
    wr(3'd0, 16'h0042);
    wr(3'd0, 16'h0043);
    wait_starts(7, 10);
    `CHECK("irq_busy", Voice_IRQ_L, 1'b1)
    bus_cycle(1'b1, 3'd1, 16'h0, d);
    `CHECK("status_q2", d, 16'h0402)
    wr(3'd2, 16'h0005);
    bus_cycle(1'b1, 3'd1, 16'h0, d);
    `CHECK("flush_mid_play", d, 16'h0600)
    `CHECK("irq_still_playing", Voice_IRQ_L, 1'b1)
    busy = 1'b0;
    repeat (2) @(negedge Clk);
    `CHECK("irq_after_done", Voice_IRQ_L, 1'b0)
    `CHECK("flush_starts", starts, 7)
    `CHECK("sel_held", phoneme_sel, 8'h41)
    busy = 1'b1;
    wr(3'd0, 16'h0076);
    wait_starts(8, 10);
    @(negedge Clk);
    VoiceSelect_H = 1'b1;
    RW = 1'b0;
    Address = 3'd0;
    DataIn = 16'h0077;
    UDS_L = 1'b0;
    LDS_L = 1'b0;
    AS_L = 1'b0;
    repeat (10) @(negedge Clk);
    `CHECK("long_dtack_low", VoiceDtack_L, 1'b0)
    AS_L = 1'b1;
    @(negedge Clk);
    `CHECK("long_dtack_release", VoiceDtack_L, 1'b1)
    VoiceSelect_H = 1'b0;
    UDS_L = 1'b1;
    LDS_L = 1'b1;
    RW = 1'b1;
    bus_cycle(1'b1, 3'd1, 16'h0, d);
    `CHECK("long_one_push", d, 16'h0401)
    `CHECK("long_starts", starts, 8)
    busy = 1'b0;
    wait_starts(9, 10);
    `CHECK("rst_play_sel", last_sel, 8'h77)
    Reset_H = 1'b1;
    repeat (2) @(negedge Clk);
    Reset_H = 1'b0;
    @(negedge Clk);
    `CHECK("post_rst_start", start_phoneme_output, 1'b0)
    `CHECK("post_rst_sel", phoneme_sel, 8'h00)
    repeat (5) @(negedge Clk);
    `CHECK("post_rst_starts", starts, 9)
    `CHECK("post_rst_irq", Voice_IRQ_L, 1'b1)
    bus_cycle(1'b1, 3'd1, 16'h0, d);
    `CHECK("post_rst_status", d, 16'h0200)
    `CHECK("pulse_width", pulse_err, 0)
    `CHECK("pulse_spacing", space_err, 0)
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
